// File: rtl/crc5_decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : crc5_decode_if
//  Purpose  : Bundle between the bit-unstuffer / protocol handler side and
//             the token-packet CRC5 decoder.
//  Signals  :
//    sop        start-of-packet strobe, one cycle          (master -> slave)
//    in_bit     received (unstuffed) bit                   (master -> slave)
//    in_valid   in_bit is valid this cycle                 (master -> slave)
//    eop        end-of-packet strobe, one cycle            (master -> slave)
//    pkt_out    reassembled PID + addr/endp, bit i = i-th received bit
//    pkt_valid  one-cycle pulse, good packet               (slave -> master)
//    crc_error  one-cycle pulse, CRC residual mismatch     (slave -> master)
//    pid_error  one-cycle pulse, PID nibble check failed   (slave -> master)
//    len_error  one-cycle pulse, wrong bit count           (slave -> master)
//    busy       packet reception in progress               (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface crc5_decode_if #(
  parameter int PID_LEN  = 8,
  parameter int DATA_LEN = 11
);
  logic                         sop;
  logic                         in_bit;
  logic                         in_valid;
  logic                         eop;
  logic [PID_LEN+DATA_LEN-1:0]  pkt_out;
  logic                         pkt_valid;
  logic                         crc_error;
  logic                         pid_error;
  logic                         len_error;
  logic                         busy;

  modport master (
    output sop, in_bit, in_valid, eop,
    input  pkt_out, pkt_valid, crc_error, pid_error, len_error, busy
  );

  modport slave (
    input  sop, in_bit, in_valid, eop,
    output pkt_out, pkt_valid, crc_error, pid_error, len_error, busy
  );
endinterface
`default_nettype wire

// File: rtl/crc5_decode.sv
`default_nettype none
// ============================================================================
//  Module   : crc5_decode
//  Purpose  : Receive-side token-packet checker. Collects the LSB-first
//             serial stream (8-bit PID, 11 addr/endp bits, 5 CRC bits),
//             reassembles the 19-bit packet, checks the PID nibbles, the
//             CRC5 residual and the packet length, and reports exactly one
//             result pulse per packet.
//  Ports    :
//    clock      system clock, rising edge
//    reset_n    asynchronous active-low reset
//    bus        crc5_decode_if slave modport (sop/in_bit/in_valid/eop in,
//               pkt_out/pkt_valid/crc_error/pid_error/len_error/busy out)
//  Revision : 1.0 - initial release
// ============================================================================
module crc5_decode #(
  parameter int PID_LEN  = 8,
  parameter int DATA_LEN = 11,
  parameter int CRC_LEN  = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  crc5_decode_if.slave  bus
);

  localparam int PKT_LEN = PID_LEN + DATA_LEN;
  localparam int TOT_LEN = PKT_LEN + CRC_LEN;
  localparam int CNT_W   = $clog2(TOT_LEN + 2);
  localparam int IDX_W   = $clog2(PKT_LEN);

  localparam logic [CNT_W-1:0]   C_PID_LEN  = CNT_W'(PID_LEN);
  localparam logic [CNT_W-1:0]   C_PKT_LEN  = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0]   C_TOT_LEN  = CNT_W'(TOT_LEN);
  // Remainder left in the register after a correct CRC has been shifted in.
  localparam logic [CRC_LEN-1:0] C_RESIDUAL = 5'b01100;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RECV_PID  = 3'd1,
    S_RECV_BODY = 3'd2,
    S_WAIT_EOP  = 3'd3,
    S_REPORT    = 3'd4
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q,  cnt_d;
  logic [PKT_LEN-1:0]   pkt_q,  pkt_d;
  logic [CRC_LEN-1:0]   crc_q,  crc_d;
  logic                 pkt_valid_q;
  logic                 crc_error_q;
  logic                 pid_error_q;
  logic                 len_error_q;
  logic                 busy_q;

  logic                 w_count;
  logic                 w_fb;
  logic                 w_pid_bad;

  // Bit acceptance: counting happens in every receiving state, but only the
  // first PKT_LEN bits are stored and only the bits after the PID are CRC'd.
  always_comb begin
    w_count = bus.in_valid &&
              ((state_q == S_RECV_PID) || (state_q == S_RECV_BODY) ||
               (state_q == S_WAIT_EOP));
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    crc_d   = crc_q;
    w_fb    = 1'b0;
    if (w_count) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q < C_PKT_LEN) begin
        pkt_d[cnt_q[IDX_W-1:0]] = bus.in_bit;
      end
      if ((cnt_q >= C_PID_LEN) && (cnt_q < C_TOT_LEN)) begin
        w_fb  = bus.in_bit ^ crc_q[4];
        crc_d = {crc_q[3], crc_q[2], crc_q[1] ^ w_fb, crc_q[0], w_fb};
      end
    end
  end

  // A valid PID carries its check nibble in the upper half.
  assign w_pid_bad = (pkt_q[PID_LEN-1:PID_LEN/2] != ~pkt_q[PID_LEN/2-1:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pkt_q       <= '0;
      crc_q       <= '1;
      pkt_valid_q <= 1'b0;
      crc_error_q <= 1'b0;
      pid_error_q <= 1'b0;
      len_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pkt_valid_q <= 1'b0;
      crc_error_q <= 1'b0;
      pid_error_q <= 1'b0;
      len_error_q <= 1'b0;

      if (bus.sop) begin
        // sop wins over everything, including a coincident bit or eop.
        state_q <= S_RECV_PID;
        cnt_q   <= '0;
        pkt_q   <= '0;
        crc_q   <= '1;
        busy_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_d;
        pkt_q <= pkt_d;
        crc_q <= crc_d;
        case (state_q)
          S_RECV_PID, S_RECV_BODY: begin
            // eop is judged against the count after any coincident bit.
            if (bus.eop) begin
              busy_q <= 1'b0;
              if (cnt_d == C_TOT_LEN) begin
                state_q <= S_REPORT;
              end else begin
                len_error_q <= 1'b1;
                state_q     <= S_IDLE;
              end
            end else if (cnt_d == C_TOT_LEN) begin
              state_q <= S_WAIT_EOP;
            end else if (cnt_d >= C_PID_LEN) begin
              state_q <= S_RECV_BODY;
            end
          end
          S_WAIT_EOP: begin
            // A bit beyond the CRC is an overlong packet, even alongside eop.
            if (bus.in_valid) begin
              len_error_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else if (bus.eop) begin
              busy_q  <= 1'b0;
              state_q <= S_REPORT;
            end
          end
          S_REPORT: begin
            state_q <= S_IDLE;
            if (w_pid_bad) begin
              pid_error_q <= 1'b1;
            end else if (crc_q != C_RESIDUAL) begin
              crc_error_q <= 1'b1;
            end else begin
              pkt_valid_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pkt_out   = pkt_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.crc_error = crc_error_q;
  assign bus.pid_error = pid_error_q;
  assign bus.len_error = len_error_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_crc5_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc5_decode
//  Purpose  : Self-checking bench for crc5_decode. Directed token scenarios
//             plus randomized packets checked against a polynomial-division
//             reference of the CRC5 residual.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc5_decode;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  crc5_decode_if bus ();

  crc5_decode dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pulse counters, sampled mid-cycle.
  int n_valid = 0;
  int n_crc   = 0;
  int n_pid   = 0;
  int n_len   = 0;
  always @(negedge clock) begin
    if (bus.pkt_valid) n_valid++;
    if (bus.crc_error) n_crc++;
    if (bus.pid_error) n_pid++;
    if (bus.len_error) n_len++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Register after the 16 covered bits = (init * x^16 + sum b_k x^(20-k)) mod
  // (x^5 + x^2 + 1), computed by plain long division.
  function automatic logic [4:0] residual(input logic [23:0] s);
    logic [20:0] p;
    p = 21'h1F0000;
    for (int k = 0; k < 16; k++) if (s[8+k]) p[20-k] = ~p[20-k];
    for (int d = 20; d >= 5; d--) if (p[d]) p = p ^ (21'h25 << (d - 5));
    return p[4:0];
  endfunction

  // Pick the CRC field by search so the packet yields the good residual.
  function automatic logic [23:0] make_valid(input logic [7:0] pid, input logic [10:0] data);
    logic [23:0] r;
    logic [23:0] s;
    r = {5'd0, data, pid};
    for (int c = 0; c < 32; c++) begin
      s = {5'(c), data, pid};
      if (residual(s) == 5'h0C) r = s;
    end
    return r;
  endfunction

  // Expected pulse as {valid,crc,pid,len} one-hot.
  function automatic logic [3:0] expect_pulse(input logic [31:0] s, input int n);
    if (n != 24) return 4'b0001;
    if (s[7:4] != ~s[3:0]) return 4'b0010;
    if (residual(s[23:0]) != 5'h0C) return 4'b0100;
    return 4'b1000;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic s, input logic v, input logic b, input logic e);
    bus.sop = s; bus.in_valid = v; bus.in_bit = b; bus.eop = e;
    @(posedge clock); #1;
    bus.sop = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.eop = 1'b0;
  endtask

  task automatic send_stream(input logic [31:0] s, input int n, input int max_gap,
                             input bit eop_with_last, input bit send_eop);
    int g;
    drive(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (g) drive(1'b0, 1'b0, 1'($urandom % 2), 1'b0);
      drive(1'b0, 1'b1, s[i], (i == n - 1) && send_eop && eop_with_last);
    end
    if (send_eop && !eop_with_last) begin
      g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (g) drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus.sop = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.eop = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({bus.pkt_out, bus.pkt_valid, bus.crc_error, bus.pid_error, bus.len_error, bus.busy} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got pkt_out=%h flags=%b%b%b%b busy=%b, required all 0",
               bus.pkt_out, bus.pkt_valid, bus.crc_error, bus.pid_error, bus.len_error, bus.busy);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if ({bus.pkt_out, bus.busy} !== 20'h0) begin
      errors++;
      $display("FAIL after_reset_idle: got pkt_out=%h busy=%b, required 0", bus.pkt_out, bus.busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_setup_token();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL setup_busy_after_sop: got %b, required 1", bus.busy);
    end
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, (i == 0 || i == 2 || i == 3 || i == 5 || i == 20), 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if ({bus.pkt_valid, bus.crc_error, bus.pid_error, bus.len_error, bus.busy} !== 5'b10000) begin
      errors++;
      $display("FAIL setup_result: got valid/crc/pid/len/busy=%b%b%b%b%b, required 10000",
               bus.pkt_valid, bus.crc_error, bus.pid_error, bus.len_error, bus.busy);
    end
    checks++;
    if (bus.pkt_out !== 19'h0002D) begin
      errors++;
      $display("FAIL setup_pkt_out: got %h, required 0002d", bus.pkt_out);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if ({bus.pkt_valid, bus.pkt_out} !== {1'b0, 19'h0002D}) begin
      errors++;
      $display("FAIL setup_single_pulse: got valid=%b pkt_out=%h, required valid=0 pkt_out=0002d",
               bus.pkt_valid, bus.pkt_out);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_crc_error();
    int b_v, b_c, b_p, b_l;
    logic [15:0] got;
    b_v = n_valid; b_c = n_crc; b_p = n_pid; b_l = n_len;
    send_stream(32'h0010102D, 24, 0, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
    got = {4'(n_valid - b_v), 4'(n_crc - b_c), 4'(n_pid - b_p), 4'(n_len - b_l)};
    checks++;
    if (got !== 16'h0100) begin
      errors++;
      $display("FAIL crc_error_pulses: got valid/crc/pid/len counts %h, required 0100", got);
    end
    checks++;
    if (bus.pkt_out !== 19'h0102D) begin
      errors++;
      $display("FAIL crc_error_pkt_out: got %h, required 0102d", bus.pkt_out);
    end
  endtask

  task automatic test_pid_error();
    int b_v, b_c, b_p, b_l;
    logic [15:0] got;
    b_v = n_valid; b_c = n_crc; b_p = n_pid; b_l = n_len;
    send_stream(32'h0010002E, 24, 0, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
    got = {4'(n_valid - b_v), 4'(n_crc - b_c), 4'(n_pid - b_p), 4'(n_len - b_l)};
    checks++;
    if (got !== 16'h0010) begin
      errors++;
      $display("FAIL pid_error_pulses: got valid/crc/pid/len counts %h, required 0010", got);
    end
  endtask

  task automatic test_short_packet();
    int b_v;
    b_v = n_valid;
    send_stream(32'h0010002D, 20, 0, 1'b0, 1'b1);
    @(negedge clock);
    checks++;
    if ({bus.len_error, bus.pkt_valid, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL short_len_error: got len/valid/busy=%b%b%b, required 100",
               bus.len_error, bus.pkt_valid, bus.busy);
    end
    @(posedge clock); #1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_valid - b_v !== 0) begin
      errors++;
      $display("FAIL short_no_valid: got %0d valid pulses, required 0", n_valid - b_v);
    end
  endtask

  task automatic test_long_packet();
    int b_v, b_c, b_p, b_l;
    logic [15:0] got;
    send_stream(32'h0110002D, 25, 0, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if ({bus.len_error, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL long_len_error: got len/busy=%b%b, required 10", bus.len_error, bus.busy);
    end
    @(posedge clock); #1;
    b_v = n_valid; b_c = n_crc; b_p = n_pid; b_l = n_len;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
    got = {4'(n_valid - b_v), 4'(n_crc - b_c), 4'(n_pid - b_p), 4'(n_len - b_l)};
    checks++;
    if (got !== 16'h0000) begin
      errors++;
      $display("FAIL long_late_eop: got valid/crc/pid/len counts %h, required 0000", got);
    end
  endtask

  task automatic test_idle_ignore();
    int b_v, b_c, b_p, b_l;
    logic [15:0] got;
    b_v = n_valid; b_c = n_crc; b_p = n_pid; b_l = n_len;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    got = {4'(n_valid - b_v), 4'(n_crc - b_c), 4'(n_pid - b_p), 4'(n_len - b_l)};
    checks++;
    if ({got, 3'b000, bus.busy} !== 20'h0) begin
      errors++;
      $display("FAIL idle_ignore: got counts %h busy=%b, required 0000 busy=0", got, bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    int b_v, b_c, b_p, b_l;
    logic [15:0] got;
    b_v = n_valid; b_c = n_crc; b_p = n_pid; b_l = n_len;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, (i == 0 || i == 2 || i == 3 || i == 5), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.pkt_out, bus.busy} !== 20'h0) begin
      errors++;
      $display("FAIL abort_async_reset: got pkt_out=%h busy=%b, required 0", bus.pkt_out, bus.busy);
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    send_stream(32'h0010002D, 24, 1, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
    got = {4'(n_valid - b_v), 4'(n_crc - b_c), 4'(n_pid - b_p), 4'(n_len - b_l)};
    checks++;
    if (got !== 16'h1000) begin
      errors++;
      $display("FAIL abort_then_good: got valid/crc/pid/len counts %h, required 1000", got);
    end
  endtask

  task automatic test_sop_restart();
    int b_v, b_c, b_p, b_l;
    logic [15:0] got;
    b_v = n_valid; b_c = n_crc; b_p = n_pid; b_l = n_len;
    send_stream(32'h00FFFFFF, 10, 0, 1'b0, 1'b0);
    send_stream(32'h0010002D, 24, 0, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
    got = {4'(n_valid - b_v), 4'(n_crc - b_c), 4'(n_pid - b_p), 4'(n_len - b_l)};
    checks++;
    if (got !== 16'h1000) begin
      errors++;
      $display("FAIL sop_restart_pulses: got valid/crc/pid/len counts %h, required 1000", got);
    end
    checks++;
    if (bus.pkt_out !== 19'h0002D) begin
      errors++;
      $display("FAIL sop_restart_pkt_out: got %h, required 0002d", bus.pkt_out);
    end
  endtask

  task automatic test_random();
    int b_v, b_c, b_p, b_l, n, sel;
    logic [15:0] got, req;
    logic [31:0] s;
    logic [3:0]  lo;
    logic [7:0]  pid;
    logic [3:0]  e;
    for (int t = 0; t < 40; t++) begin
      lo  = 4'($urandom);
      pid = ($urandom_range(4, 0) == 0) ? 8'($urandom) : {~lo, lo};
      s   = {8'($urandom), make_valid(pid, 11'($urandom))};
      if ($urandom_range(3, 0) == 0) s[$urandom_range(23, 8)] ^= 1'b1;
      sel = $urandom_range(9, 0);
      n   = (sel == 0) ? $urandom_range(23, 19) : (sel == 1) ? 25 : 24;
      e   = expect_pulse(s, n);
      req = {3'b000, e[3], 3'b000, e[2], 3'b000, e[1], 3'b000, e[0]};
      b_v = n_valid; b_c = n_crc; b_p = n_pid; b_l = n_len;
      send_stream(s, n, 2, 1'($urandom % 2), 1'b1);
      repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
      got = {4'(n_valid - b_v), 4'(n_crc - b_c), 4'(n_pid - b_p), 4'(n_len - b_l)};
      checks++;
      if (got !== req) begin
        errors++;
        $display("FAIL random_pulses[%0d]: stream=%h n=%0d got counts %h, required %h", t, s, n, got, req);
      end
      checks++;
      if ({bus.pkt_out, bus.busy} !== {s[18:0], 1'b0}) begin
        errors++;
        $display("FAIL random_pkt_out[%0d]: got pkt_out=%h busy=%b, required pkt_out=%h busy=0",
                 t, bus.pkt_out, bus.busy, s[18:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_setup_token();
    test_crc_error();
    test_pid_error();
    test_short_packet();
    test_long_packet();
    test_idle_ignore();
    test_reset_abort();
    test_sop_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc5_decode.md
Name: crc5_decode

Overview:
- Receive-side counterpart of the token-packet CRC5 encoder.
- Accepts the serial bit stream from the bit-unstuffer, LSB first: 8-bit PID, 11 data bits (addr+endp), 5 CRC bits.
- Reassembles the 19-bit packet, checks the PID, checks the CRC5 residual and detects length errors.
- Reports exactly one result per packet to the protocol handler.

Parameters:
- PID_LEN, 8, PID bits received before CRC coverage starts.
- DATA_LEN, 11, CRC-covered payload bits.
- CRC_LEN, 5, CRC bits. Fixed by the polynomial; not to be overridden.

Ports:
- clock      input   1   system clock, posedge
- reset_n    input   1   asynchronous, active-low reset
- sop        input   1   start-of-packet strobe, one cycle
- in_bit     input   1   received (unstuffed) bit
- in_valid   input   1   in_bit is valid this cycle
- eop        input   1   end-of-packet strobe, one cycle
- pkt_out    output  19  reassembled packet; bit i = i-th received bit (PID in [7:0])
- pkt_valid  output  1   one-cycle pulse: good packet
- crc_error  output  1   one-cycle pulse: CRC residual mismatch
- pid_error  output  1   one-cycle pulse: PID[7:4] != ~PID[3:0]
- len_error  output  1   one-cycle pulse: bit count != 24 at eop, or a 25th bit arrived
- busy       output  1   high from sop until the result pulse or abort

Behaviour:
- Reset (async): state IDLE; all outputs 0; pkt_out = 0; CRC regs x0..x4 = 1; bit counter = 0.
- FSM states:
  - IDLE.
  - RECV_PID: counter 0..7.
  - RECV_BODY: counter 8..23.
  - WAIT_EOP: counter = 24.
  - REPORT.
- Transitions:
  - sop in any state → clear counter, preload CRC regs to 1, go to RECV_PID. sop overrides everything else in that cycle.
  - in_valid coincident with sop is ignored.
- Accepting a bit:
  - On in_valid outside IDLE/REPORT: counter increments.
  - If counter < 19: in_bit is written to pkt_out[counter].
  - If 8 ≤ counter ≤ 23: CRC update with fb = in_bit ^ x4; x0←fb; x1←x0; x2←x1^fb; x3←x2; x4←x3.
  - PID bits never enter the CRC.
- RECV_PID → RECV_BODY when the 8th bit is accepted. RECV_BODY → WAIT_EOP when the 24th bit is accepted.
- in_valid in WAIT_EOP (25th bit): len_error pulse next cycle, then IDLE. Further bits are ignored until sop.
- eop handling:
  - eop in RECV_PID/RECV_BODY: len_error pulse next cycle, then IDLE.
  - eop in WAIT_EOP → REPORT.
  - eop with in_valid in the same cycle: the bit is accepted first, then eop is evaluated against the updated count.
- REPORT (single cycle, registered outputs, so the pulse appears the cycle after REPORT is entered):
  - pid_error if PID check fails (takes priority).
  - else crc_error if {x4,x3,x2,x1,x0} != 5'b01100.
  - else pkt_valid.
  - Exactly one pulse, then IDLE.
- pkt_out holds its value after the result and until the next sop. It is not cleared on error.
- busy = 1 in RECV_PID, RECV_BODY, WAIT_EOP.
- eop or in_valid in IDLE: ignored, no pulses.
- reset_n asserted mid-packet: immediate return to reset values. No pulse is produced for the aborted packet.

Test Plan:
- SETUP token, addr 0, endp 0: sop; bits 1,0,1,1,0,1,0,0 (PID 0x2D), 11×0, then CRC bits 0,1,0,0,0; eop → pkt_valid = 1 for one cycle, pkt_out = 19'h0002D, all error flags 0.
- Same stream with data bit 12 flipped to 1 → crc_error pulse only; pkt_out = 19'h0102D.
- PID bits forming 0x2E (nibble check fails) with otherwise correct CRC → pid_error pulse only, no crc_error.
- eop after 20 bits → len_error pulse; no pkt_valid; busy falls.
- 25 bits with no eop → len_error the cycle after the 25th bit; a later eop produces no pulse.
- Mid-packet: reset_n low at bit 15, then a full valid SETUP packet → no pulse for the first packet, pkt_valid for the second. Also sop at bit 10 followed by a full valid packet → single pkt_valid.
